// File: rtl/axi_demux_pkg.sv
// axi_demux_pkg: shared payload widths, field offsets and response codes for the AXI write demux
package axi_demux_pkg;
  // Fixed-width AW fields between ADDR and USER: LEN8 SIZE3 BURST2 LOCK1 CACHE4 PROT3 QOS4 REGION4
  localparam int AW_FIX_W = 29;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {DE_IDLE, DE_DATA, DE_RESP} de_state_t;
  // AW = {ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,REGION,USER}
  function automatic int aw_width(input int id_w, input int addr_w, input int user_w);
    return id_w + addr_w + AW_FIX_W + user_w;
  endfunction
  function automatic int aw_addr_lsb(input int user_w);
    return user_w + AW_FIX_W;
  endfunction
  function automatic int aw_id_lsb(input int addr_w, input int user_w);
    return user_w + AW_FIX_W + addr_w;
  endfunction
  // W = {DATA,STRB,LAST,USER}; LAST sits directly above USER
  function automatic int w_width(input int data_w, input int user_w);
    return data_w + data_w / 8 + 1 + user_w;
  endfunction
  function automatic int w_last_bit(input int user_w);
    return user_w;
  endfunction
  // B = {ID,RESP,USER}
  function automatic int b_width(input int id_w, input int user_w);
    return id_w + 2 + user_w;
  endfunction
endpackage

// File: rtl/axi_route_fifo.sv
// axi_route_fifo: synchronous FIFO holding the slave route of each accepted AW burst
// Ports: ACLK/ARESETn (sync, active-low), push/din write, pop/dout read head, empty flag.
// Caller never pushes when full or pops when empty.
module axi_route_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] wp, rp;
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        mem[wp[PW-1:0]] <= din;
        wp <= wp + (PW+1)'(1);
      end
      if (pop) rp <= rp + (PW+1)'(1);
    end
  end
  assign dout = mem[rp[PW-1:0]];
  assign empty = wp == rp;
endmodule

// File: rtl/axi_slave_demux_w.sv
// axi_slave_demux_w: 1-to-NUM_SLAVES AXI4 write-path demux with outstanding tracking and W/B routing
// Ports: ACLK, ARESETn (sync, active-low); upstream s2m_AW/W/B with VALID/READY;
//   per-slave m_AW/m_W (broadcast payload), m_AWVALID/m_WVALID/m_BREADY outputs, m_B/m_BVALID/m_AWREADY/m_WREADY inputs.
// Option: define AXI_DEMUX_DECERR_EN to answer unmapped addresses from an internal DECERR slave;
//   otherwise unmapped addresses go to slave NUM_SLAVES-1.
module axi_slave_demux_w
  import axi_demux_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH = 8,
  parameter int USER_WIDTH = 8,
  parameter int DEC_LSB = 28,
  parameter int SEL_WIDTH = $clog2(NUM_SLAVES),
  parameter int MAX_OUTSTANDING = 4,
  localparam int AW_W = aw_width(ID_WIDTH, ADDR_WIDTH, USER_WIDTH),
  localparam int W_W = w_width(DATA_WIDTH, USER_WIDTH),
  localparam int B_W = b_width(ID_WIDTH, USER_WIDTH)
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [AW_W-1:0]            s2m_AW,
  input  logic                       s2m_AWVALID,
  output logic                       s2m_AWREADY,
  input  logic [W_W-1:0]             s2m_W,
  input  logic                       s2m_WVALID,
  output logic                       s2m_WREADY,
  output logic [B_W-1:0]             s2m_B,
  output logic                       s2m_BVALID,
  input  logic                       s2m_BREADY,
  output logic [NUM_SLAVES*AW_W-1:0] m_AW,
  output logic [NUM_SLAVES-1:0]      m_AWVALID,
  input  logic [NUM_SLAVES-1:0]      m_AWREADY,
  output logic [NUM_SLAVES*W_W-1:0]  m_W,
  output logic [NUM_SLAVES-1:0]      m_WVALID,
  input  logic [NUM_SLAVES-1:0]      m_WREADY,
  input  logic [NUM_SLAVES*B_W-1:0]  m_B,
  input  logic [NUM_SLAVES-1:0]      m_BVALID,
  output logic [NUM_SLAVES-1:0]      m_BREADY
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int ADDR_LSB = aw_addr_lsb(USER_WIDTH);
  localparam logic [SEL_WIDTH:0] NS = (SEL_WIDTH+1)'(NUM_SLAVES);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [SEL_WIDTH-1:0] DEF_SEL = SEL_WIDTH'(NUM_SLAVES - 1);
  logic [CW-1:0] cnt;
  logic [SEL_WIDTH-1:0] tgt, aw_idx, aw_sel, h_sel;
  logic tgt_err, aw_err, aw_unmapped, aw_ok, aw_hs, w_last_hs, b_hs, f_empty, h_err, busy;
  logic de_bvalid;
  logic [B_W-1:0] de_b;
  assign aw_idx = s2m_AW[ADDR_LSB+DEC_LSB +: SEL_WIDTH];
  assign aw_unmapped = {1'b0, aw_idx} >= NS;
`ifdef AXI_DEMUX_DECERR_EN
  assign aw_err = aw_unmapped;
  assign aw_sel = aw_idx;
`else
  assign aw_err = 1'b0;
  assign aw_sel = aw_unmapped ? DEF_SEL : aw_idx;
`endif
  assign busy = cnt != '0;
  // Only one target may have bursts in flight, so B responses come back in issue order.
  // The error slave never shares the window with anyone, hence the !aw_err / !tgt_err terms.
  assign aw_ok = ARESETn && cnt < MAX_CNT && (!busy || (aw_sel == tgt && !tgt_err && !aw_err));
  assign s2m_AWREADY = aw_ok && (aw_err || m_AWREADY[aw_sel]);
  assign aw_hs = s2m_AWVALID && s2m_AWREADY;
  assign m_AW = {NUM_SLAVES{s2m_AW}};
  assign m_W = {NUM_SLAVES{s2m_W}};
  axi_route_fifo #(
    .WIDTH(SEL_WIDTH + 1),
    .DEPTH(MAX_OUTSTANDING)
  ) u_route (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .push   (aw_hs),
    .din    ({aw_err, aw_sel}),
    .pop    (w_last_hs),
    .dout   ({h_err, h_sel}),
    .empty  (f_empty)
  );
  assign s2m_WREADY = ARESETn && !f_empty && (h_err || m_WREADY[h_sel]);
  assign w_last_hs = s2m_WVALID && s2m_WREADY && s2m_W[w_last_bit(USER_WIDTH)];
  assign s2m_BVALID = ARESETn && busy && (tgt_err ? de_bvalid : m_BVALID[tgt]);
  assign s2m_B = tgt_err ? de_b : m_B[tgt*B_W +: B_W];
  assign b_hs = s2m_BVALID && s2m_BREADY;
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sl
    assign m_AWVALID[i] = aw_ok && s2m_AWVALID && !aw_err && aw_sel == SEL_WIDTH'(i);
    assign m_WVALID[i] = ARESETn && !f_empty && !h_err && h_sel == SEL_WIDTH'(i) && s2m_WVALID;
    assign m_BREADY[i] = ARESETn && busy && !tgt_err && tgt == SEL_WIDTH'(i) && s2m_BREADY;
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt <= '0;
      tgt <= '0;
      tgt_err <= 1'b0;
    end else begin
      cnt <= cnt + CW'(aw_hs) - CW'(b_hs);
      if (aw_hs) begin
        tgt <= aw_sel;
        tgt_err <= aw_err;
      end
    end
  end
`ifdef AXI_DEMUX_DECERR_EN
  de_state_t de_state, de_next;
  logic [ID_WIDTH-1:0] de_id;
  always_ff @(posedge ACLK) begin
    if (!ARESETn) de_state <= DE_IDLE;
    else de_state <= de_next;
  end
  always_ff @(posedge ACLK) begin
    if (aw_hs && aw_err) de_id <= s2m_AW[aw_id_lsb(ADDR_WIDTH, USER_WIDTH) +: ID_WIDTH];
  end
  // Response is registered: BVALID rises the cycle after the WLAST beat is sunk.
  always_comb begin
    de_next = de_state;
    de_next = (de_state == DE_IDLE && aw_hs && aw_err) ? DE_DATA :
              (de_state == DE_DATA && w_last_hs && h_err) ? DE_RESP :
              (de_state == DE_RESP && b_hs) ? DE_IDLE : de_state;
  end
  assign de_bvalid = de_state == DE_RESP;
  assign de_b = {de_id, RESP_DECERR, {USER_WIDTH{1'b0}}};
`else
  assign de_bvalid = 1'b0;
  assign de_b = '0;
`endif
endmodule

// File: tb/tb_axi_slave_demux_w.sv
// tb_axi_slave_demux_w: scoreboard bench for the AXI write demux (4-slave main DUT, 3-slave unmapped-address DUT)
module tb_axi_slave_demux_w;
  localparam int AWW = 109;
  localparam int WW = 81;
  localparam int BW = 18;
  typedef struct {int s; logic [127:0] p;} ev_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [AWW-1:0] aw;
  logic aw_v, aw_r;
  logic [WW-1:0] w;
  logic w_v, w_r;
  logic [BW-1:0] b;
  logic b_v, b_r;
  logic [4*AWW-1:0] m_aw;
  logic [3:0] m_aw_v, m_aw_r;
  logic [4*WW-1:0] m_w;
  logic [3:0] m_w_v, m_w_r;
  logic [4*BW-1:0] m_b;
  logic [3:0] m_b_v, m_b_r;
  logic [AWW-1:0] d_aw;
  logic d_aw_v, d_aw_r;
  logic [WW-1:0] d_w;
  logic d_w_v, d_w_r;
  logic [BW-1:0] d_b;
  logic d_b_v, d_b_r;
  logic [3*AWW-1:0] d_m_aw;
  logic [2:0] d_m_aw_v, d_m_aw_r;
  logic [3*WW-1:0] d_m_w;
  logic [2:0] d_m_w_v, d_m_w_r;
  logic [3*BW-1:0] d_m_b;
  logic [2:0] d_m_b_v, d_m_b_r;
  int n_chk = 0;
  int n_fail = 0;
  ev_t q_aw[$];
  ev_t q_w[$];
  logic [127:0] q_b[$];
  ev_t ea, ew;
  axi_slave_demux_w #(.NUM_SLAVES(4), .DEC_LSB(28), .MAX_OUTSTANDING(4)) u0 (
    .ACLK(clk), .ARESETn(rst_n),
    .s2m_AW(aw), .s2m_AWVALID(aw_v), .s2m_AWREADY(aw_r),
    .s2m_W(w), .s2m_WVALID(w_v), .s2m_WREADY(w_r),
    .s2m_B(b), .s2m_BVALID(b_v), .s2m_BREADY(b_r),
    .m_AW(m_aw), .m_AWVALID(m_aw_v), .m_AWREADY(m_aw_r),
    .m_W(m_w), .m_WVALID(m_w_v), .m_WREADY(m_w_r),
    .m_B(m_b), .m_BVALID(m_b_v), .m_BREADY(m_b_r)
  );
  axi_slave_demux_w #(.NUM_SLAVES(3), .DEC_LSB(28), .MAX_OUTSTANDING(4)) u1 (
    .ACLK(clk), .ARESETn(rst_n),
    .s2m_AW(d_aw), .s2m_AWVALID(d_aw_v), .s2m_AWREADY(d_aw_r),
    .s2m_W(d_w), .s2m_WVALID(d_w_v), .s2m_WREADY(d_w_r),
    .s2m_B(d_b), .s2m_BVALID(d_b_v), .s2m_BREADY(d_b_r),
    .m_AW(d_m_aw), .m_AWVALID(d_m_aw_v), .m_AWREADY(d_m_aw_r),
    .m_W(d_m_w), .m_WVALID(d_m_w_v), .m_WREADY(d_m_w_r),
    .m_B(d_m_b), .m_BVALID(d_m_b_v), .m_BREADY(d_m_b_r)
  );
  function automatic logic [AWW-1:0] mk_aw(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len);
    return {id, addr, len, 3'd3, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 8'h00};
  endfunction
  function automatic logic [WW-1:0] mk_w(input logic [63:0] data, input logic last);
    return {data, 8'hFF, last, 8'h00};
  endfunction
  function automatic logic [BW-1:0] mk_b(input logic [7:0] id, input logic [1:0] resp);
    return {id, resp, 8'h00};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic aw_drive(input logic [63:0] addr, input logic [7:0] id, input logic [7:0] len, input int s);
    ev_t e;
    aw = mk_aw(id, addr, len);
    aw_v = 1'b1;
    e.s = s;
    e.p = 128'(aw);
    q_aw.push_back(e);
  endtask
  task automatic aw_wait;
    bit ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = aw_r;
    end
    chk("aw_accept", 128'(ok), 128'(1));
    tick;
    aw_v = 1'b0;
  endtask
  task automatic aw_go(input logic [63:0] addr, input logic [7:0] id, input logic [7:0] len, input int s);
    aw_drive(addr, id, len, s);
    aw_wait;
  endtask
  task automatic w_wait;
    bit ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = w_r;
    end
    chk("w_accept", 128'(ok), 128'(1));
    tick;
    w_v = 1'b0;
  endtask
  task automatic w_burst(input int s, input int n, input logic [63:0] base);
    ev_t e;
    for (int k = 0; k < n; k++) begin
      w = mk_w(base + 64'(k), k == n - 1);
      w_v = 1'b1;
      e.s = s;
      e.p = 128'(w);
      q_w.push_back(e);
      w_wait;
    end
  endtask
  task automatic b_send(input int s, input logic [7:0] id, input logic [1:0] resp);
    bit ok = 1'b0;
    m_b[s*BW +: BW] = mk_b(id, resp);
    m_b_v[s] = 1'b1;
    q_b.push_back(128'(mk_b(id, resp)));
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = m_b_r[s];
    end
    chk("b_accept", 128'(ok), 128'(1));
    tick;
    m_b_v[s] = 1'b0;
  endtask
  task automatic aw_stall(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      chk({name, "_awready"}, 128'(aw_r), 128'(0));
      chk({name, "_m_awvalid"}, 128'(m_aw_v), 128'(0));
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (m_aw_v[i] && m_aw_r[i]) begin
        if (q_aw.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL aw_unexpected: slave %0d took an AW, expected none", i);
        end else begin
          ea = q_aw.pop_front();
          chk("aw_slave", 128'(i), 128'(ea.s));
          chk("aw_payload", 128'(m_aw[i*AWW +: AWW]), ea.p);
        end
      end
      if (m_w_v[i] && m_w_r[i]) begin
        if (q_w.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL w_unexpected: slave %0d took a W beat, expected none", i);
        end else begin
          ew = q_w.pop_front();
          chk("w_slave", 128'(i), 128'(ew.s));
          chk("w_payload", 128'(m_w[i*WW +: WW]), ew.p);
        end
      end
    end
    if (|m_aw_v) chk("aw_onehot", 128'($onehot(m_aw_v)), 128'(1));
    if (b_v && b_r) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected: got B %0h, expected none", b);
      end else chk("b_payload", 128'(b), q_b.pop_front());
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    aw = mk_aw(8'h01, 64'h1000_0000, 8'd0);
    aw_v = 1'b1;
    w = mk_w(64'h1, 1'b1);
    w_v = 1'b1;
    b_r = 1'b1;
    m_aw_r = 4'hF;
    m_w_r = 4'hF;
    m_b = '0;
    m_b_v = 4'hF;
    d_aw = '0;
    d_aw_v = 1'b0;
    d_w = '0;
    d_w_v = 1'b0;
    d_b_r = 1'b0;
    d_m_aw_r = 3'b111;
    d_m_w_r = 3'b111;
    d_m_b = '0;
    d_m_b_v = 3'b000;
    repeat (2) @(negedge clk);
    chk("rst_awready", 128'(aw_r), 128'(0));
    chk("rst_wready", 128'(w_r), 128'(0));
    chk("rst_bvalid", 128'(b_v), 128'(0));
    chk("rst_m_awvalid", 128'(m_aw_v), 128'(0));
    chk("rst_m_wvalid", 128'(m_w_v), 128'(0));
    chk("rst_m_bready", 128'(m_b_r), 128'(0));
    aw_v = 1'b0;
    w_v = 1'b0;
    m_b_v = 4'h0;
    tick;
    rst_n = 1'b1;
    tick;
    aw_drive(64'h2000_0000, 8'h11, 8'd3, 2);
    #1;
    chk("t1_m_awvalid", 128'(m_aw_v), 128'(4'b0100));
    aw_wait;
    w_burst(2, 4, 64'hA0);
    b_send(2, 8'h11, 2'b00);
    begin
      ev_t e;
      w = mk_w(64'hB0, 1'b1);
      w_v = 1'b1;
      e.s = 0;
      e.p = 128'(w);
      q_w.push_back(e);
    end
    repeat (3) begin
      @(negedge clk);
      chk("t4_wready", 128'(w_r), 128'(0));
      chk("t4_m_wvalid", 128'(m_w_v), 128'(0));
    end
    tick;
    aw_go(64'h0000_0000, 8'h22, 8'd0, 0);
    w_wait;
    b_send(0, 8'h22, 2'b00);
    aw_go(64'h1000_0000, 8'h31, 8'd0, 1);
    w_burst(1, 1, 64'hC0);
    aw_go(64'h1000_0040, 8'h32, 8'd1, 1);
    w_burst(1, 2, 64'hD0);
    aw_drive(64'h3000_0000, 8'h33, 8'd0, 3);
    aw_stall("t2_two_out", 3);
    tick;
    b_send(1, 8'h31, 2'b00);
    aw_stall("t2_one_out", 1);
    tick;
    b_send(1, 8'h32, 2'b10);
    aw_wait;
    w_burst(3, 1, 64'hE0);
    b_send(3, 8'h33, 2'b00);
    for (int k = 0; k < 4; k++) aw_go(64'(k * 64), 8'(8'h40 + k), 8'd0, 0);
    aw_drive(64'h100, 8'h44, 8'd0, 0);
    aw_stall("t3_full", 3);
    tick;
    for (int k = 0; k < 4; k++) w_burst(0, 1, 64'(64'hF0 + k));
    aw_stall("t3_full_w", 1);
    tick;
    b_send(0, 8'h40, 2'b00);
    aw_wait;
    w_burst(0, 1, 64'hF4);
    for (int k = 1; k < 5; k++) b_send(0, 8'(8'h40 + k), 2'b00);
    aw_go(64'h1000_0000, 8'h61, 8'd1, 1);
    aw_go(64'h1000_0000, 8'h62, 8'd0, 1);
    begin
      ev_t e;
      w = mk_w(64'h70, 1'b0);
      w_v = 1'b1;
      e.s = 1;
      e.p = 128'(w);
      q_w.push_back(e);
    end
    w_wait;
    w = mk_w(64'h71, 1'b1);
    w_v = 1'b1;
    aw = mk_aw(8'h6F, 64'h1000_0000, 8'd0);
    aw_v = 1'b1;
    m_b_v[1] = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_awready", 128'(aw_r), 128'(0));
    chk("t6_wready", 128'(w_r), 128'(0));
    chk("t6_bvalid", 128'(b_v), 128'(0));
    chk("t6_m_awvalid", 128'(m_aw_v), 128'(0));
    chk("t6_m_wvalid", 128'(m_w_v), 128'(0));
    chk("t6_m_bready", 128'(m_b_r), 128'(0));
    tick;
    aw_v = 1'b0;
    w_v = 1'b0;
    m_b_v = 4'h0;
    rst_n = 1'b1;
    tick;
    aw_go(64'h1000_0000, 8'h63, 8'd0, 1);
    w_burst(1, 1, 64'h80);
    b_send(1, 8'h63, 2'b00);
    aw_go(64'h3000_0000, 8'h64, 8'd0, 3);
    w_burst(3, 1, 64'h90);
    b_send(3, 8'h64, 2'b00);
    d_aw = mk_aw(8'h5A, 64'h3000_0000, 8'd1);
    d_aw_v = 1'b1;
    #1;
`ifdef AXI_DEMUX_DECERR_EN
    chk("de_m_awvalid", 128'(d_m_aw_v), 128'(0));
    chk("de_awready", 128'(d_aw_r), 128'(1));
    tick;
    d_aw_v = 1'b0;
    d_w = mk_w(64'h1, 1'b0);
    d_w_v = 1'b1;
    #1;
    chk("de_w1_wready", 128'(d_w_r), 128'(1));
    chk("de_w1_m_wvalid", 128'(d_m_w_v), 128'(0));
    tick;
    d_w = mk_w(64'h2, 1'b1);
    #1;
    chk("de_w2_wready", 128'(d_w_r), 128'(1));
    chk("de_w2_bvalid", 128'(d_b_v), 128'(0));
    tick;
    d_w_v = 1'b0;
    #1;
    chk("de_bvalid", 128'(d_b_v), 128'(1));
    chk("de_b", 128'(d_b), 128'({8'h5A, 2'b11, 8'h00}));
    tick;
    chk("de_bvalid_held", 128'(d_b_v), 128'(1));
    d_b_r = 1'b1;
    tick;
    chk("de_bvalid_done", 128'(d_b_v), 128'(0));
    d_aw = mk_aw(8'h01, 64'h0, 8'd0);
    d_aw_v = 1'b1;
    #1;
    chk("de_next_m_awvalid", 128'(d_m_aw_v), 128'(3'b001));
    tick;
    d_aw_v = 1'b0;
`else
    chk("dflt_m_awvalid", 128'(d_m_aw_v), 128'(3'b100));
    chk("dflt_awready", 128'(d_aw_r), 128'(1));
    tick;
    d_aw_v = 1'b0;
    d_w = mk_w(64'h1, 1'b0);
    d_w_v = 1'b1;
    #1;
    chk("dflt_w1_m_wvalid", 128'(d_m_w_v), 128'(3'b100));
    tick;
    d_w = mk_w(64'h2, 1'b1);
    #1;
    chk("dflt_w2_m_wvalid", 128'(d_m_w_v), 128'(3'b100));
    tick;
    d_w_v = 1'b0;
    d_m_b[2*BW +: BW] = mk_b(8'h5A, 2'b00);
    d_m_b_v[2] = 1'b1;
    d_b_r = 1'b1;
    #1;
    chk("dflt_bvalid", 128'(d_b_v), 128'(1));
    chk("dflt_b", 128'(d_b), 128'({8'h5A, 2'b00, 8'h00}));
    chk("dflt_m_bready", 128'(d_m_b_r), 128'(3'b100));
    tick;
    d_m_b_v = 3'b000;
    #1;
    chk("dflt_bvalid_done", 128'(d_b_v), 128'(0));
`endif
    repeat (4) tick;
    chk("q_aw_drained", 128'(q_aw.size()), 128'(0));
    chk("q_w_drained", 128'(q_w.size()), 128'(0));
    chk("q_b_drained", 128'(q_b.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
